biquad8_coeff_loader: RTL and testbench
=======================================

Name: biquad8_coeff_loader

Overview:
Sequences coefficient loading into one biquad8 incremental IIR stage. Holds a host-writable shadow bank of all per-DSP B coefficients. On commit, streams the bank into the DSP B1 cascade chain with coeff_wr, then issues one coeff_update pulse so every B2 register switches at once. Sits between the register/config interface and the IIR datapath's coeff_dat/coeff_wr/coeff_update inputs.

Parameters:
NSAMP, 8, samples per clock of the attached IIR; chain has 2*(NSAMP-2) DSPs.
CBITS, 18, coefficient width (DSP B port).
NCOEFF, 2*(NSAMP-2), localparam; shadow bank depth (12 at default).
ABITS, $clog2(NCOEFF), localparam; config address width (4 at default).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
cfg_addr_i  in  ABITS  shadow entry index
cfg_dat_i  in  CBITS  shadow write data
cfg_wr_i  in  1  shadow write strobe
commit_i  in  1  single-cycle request to load shadow into datapath
busy_o  out  1  load sequence in progress
done_o  out  1  one-cycle pulse, load + update complete
err_o  out  1  one-cycle pulse, rejected write or commit
coeff_dat_o  out  CBITS  to IIR coeff_dat input
coeff_wr_o  out  1  to IIR coeff_wr input (B1 shift enable)
coeff_update_o  out  1  to IIR coeff_update input (B2 load enable)

Behaviour:
- Clocking: one clock, clk. rst_n is synchronous and active-low.
- Reset: busy_o, done_o, err_o, coeff_wr_o, coeff_update_o and coeff_dat_o all 0. State goes to IDLE. Shadow contents are not reset; they power up as 0.
- Shadow index map: entry 2*(s-2) is the low DSP (coeff0 tap) of sample s. Entry 2*(s-2)+1 is the high DSP (coeff1 tap). Valid s is 2..NSAMP-1.
- Chain order: the first word shifted in lands in the farthest DSP, so words stream from index NCOEFF-1 down to 0.
- Datapath timing fact: the IIR registers its B clock enables one cycle inside the datapath. Data must therefore lag coeff_wr_o by one cycle.
- coeff_dat_o is the registered read of the shadow bank. Read address issued in cycle t appears in cycle t+1.
- FSM states: IDLE, LOAD, UPDATE.
- IDLE: a valid cfg_wr_i writes the shadow. commit_i moves to LOAD next cycle.
- LOAD (cycles 1..NCOEFF after the commit cycle 0):
  - coeff_wr_o = 1 every cycle.
  - Read address in LOAD cycle j (j = 0..NCOEFF-1) is NCOEFF-1-j, so coeff_dat_o in cycle j+2 = shadow[NCOEFF-1-j].
  - Down-counter; at 0 go to UPDATE.
- UPDATE (cycle NCOEFF+1): coeff_update_o = 1 for exactly one cycle. coeff_dat_o = shadow[0]. Then go to IDLE.
- Cycle NCOEFF+2: done_o = 1 and busy_o = 0.
- busy_o: 1 from cycle 1 through cycle NCOEFF+1 inclusive.
- Commit-to-done latency: NCOEFF+2 cycles (14 at default).
- Outside LOAD/UPDATE, coeff_dat_o holds its last value.
- cfg_wr_i and commit_i in the same IDLE cycle: the write lands first and is included in the stream.
- cfg_wr_i while busy_o = 1: dropped, shadow unchanged, err_o pulses next cycle.
- commit_i while busy_o = 1: dropped (not queued), err_o pulses next cycle.
- commit_i on the done_o cycle: accepted, since the FSM is already in IDLE.
- cfg_addr_i >= NCOEFF with cfg_wr_i: write ignored, err_o pulses.
- Simultaneous err causes in one cycle produce a single err_o pulse.
- Reset mid-LOAD/UPDATE:
  - All outputs return to 0 and the FSM goes to IDLE with no coeff_update_o pulse.
  - Active B2 coefficients are therefore untouched; B1 holds a partial chain. Host must commit again.
- Width: data passes unmodified, no arithmetic, CBITS bits end to end.

Decomposition:
- Package biquad8_ctrl_pkg holds:
  - state enum {IDLE, LOAD, UPDATE};
  - function ncoeff(nsamp) = 2*(nsamp-2);
  - constant COEFF_BITS = 18.
- One sub-module is natural: biquad8_coeff_shadow, an NCOEFF x CBITS distributed RAM with a synchronous write port and a registered read port.

Test Plan:
1. NSAMP=8. Write shadow[k] = k+1 for k = 0..11, commit at cycle 0.
   -> coeff_wr_o high cycles 1-12.
   -> coeff_dat_o = 12,11,...,1 in cycles 2-13.
   -> coeff_update_o high only in cycle 13; done_o in cycle 14; busy_o high cycles 1-13.
2. Same cycle: cfg_wr_i with addr 11, data 0x3FFFF, plus commit_i -> first streamed word (cycle 2) = 0x3FFFF.
3. During load: write addr 3 and assert commit_i at cycle 5 -> err_o pulse in cycle 6, shadow[3] unchanged, only one update pulse, done_o at 14.
4. rst_n low in cycle 6 of a load -> cycle 7: all outputs 0, no update. Fresh commit -> full 12-word stream and update.
5. Commit on the done_o cycle -> coeff_wr_o asserted next cycle, second load identical to the first.
6. Writes to addr 12-15 -> err_o pulse each time; a subsequent load streams unchanged contents.

Source files
------------

// File: rtl/biquad8_coeff_loader_pkg.sv
// Shared types and sizing helpers for the biquad8 coefficient loader.
// The chain length follows from the IIR sample count.
package biquad8_ctrl_pkg;

    localparam int COEFF_BITS = 18;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        UPDATE
    } state_t;

    // Two DSPs (coeff0 and coeff1 taps) per sample, for samples 2..NSAMP-1.
    function automatic int ncoeff(input int nsamp);
        return 2 * (nsamp - 2);
    endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// Host-side configuration bus of the coefficient loader: shadow writes,
// commit request, and the busy/done/err status returned to the host.
interface biquad8_coeff_loader_if
    import biquad8_ctrl_pkg::*;
#(
    parameter int ABITS = 4,
    parameter int CBITS = COEFF_BITS
);
    logic [ABITS-1:0] cfg_addr;
    logic [CBITS-1:0] cfg_dat;
    logic             cfg_wr;
    logic             commit;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cfg_addr, cfg_dat, cfg_wr, commit,
        input  busy, done, err
    );

    modport slave (
        input  cfg_addr, cfg_dat, cfg_wr, commit,
        output busy, done, err
    );
endinterface

// File: rtl/biquad8_coeff_shadow.sv
// Shadow bank of B coefficients: synchronous write port and a registered
// read port whose output holds between reads.
module biquad8_coeff_shadow
    import biquad8_ctrl_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int ABITS = 4,
    parameter int CBITS = COEFF_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [ABITS-1:0] i_wr_addr,
    input  logic [CBITS-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [ABITS-1:0] i_rd_addr,
    output logic [CBITS-1:0] o_rd_dat
);
    logic [CBITS-1:0] r_mem [DEPTH];
    logic [CBITS-1:0] r_rd_dat;

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/biquad8_coeff_loader.sv
// Streams the shadow bank into the DSP B1 cascade (farthest DSP first), then
// issues one coeff_update pulse so all B2 registers switch together.
module biquad8_coeff_loader
    import biquad8_ctrl_pkg::*;
#(
    parameter int NSAMP = 8,
    parameter int CBITS = COEFF_BITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    biquad8_coeff_loader_if.slave   cfg,
    output logic [CBITS-1:0]        coeff_dat_o,
    output logic                    coeff_wr_o,
    output logic                    coeff_update_o
);
    localparam int NCOEFF = ncoeff(NSAMP);
    localparam int ABITS  = $clog2(NCOEFF);

    state_t           r_state, w_state_next;
    logic [ABITS-1:0] r_cnt, w_cnt_next;
    logic             r_done, r_err;
    logic             w_busy, w_addr_ok, w_wr_en, w_rd_en, w_err_next;
    logic             w_coeff_wr, w_coeff_update;
    logic [CBITS-1:0] w_rd_dat;

    assign w_busy    = (r_state != IDLE);
    assign w_addr_ok = (int'(cfg.cfg_addr) < NCOEFF);
    assign w_wr_en   = cfg.cfg_wr && !w_busy && w_addr_ok;
    // All rejection causes collapse into one pulse on the following cycle.
    assign w_err_next = (cfg.cfg_wr && (w_busy || !w_addr_ok)) ||
                        (cfg.commit && w_busy);

    biquad8_coeff_shadow #(
        .DEPTH (NCOEFF),
        .ABITS (ABITS),
        .CBITS (CBITS)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (cfg.cfg_addr),
        .i_wr_dat  (cfg.cfg_dat),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_cnt),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= (r_state == UPDATE);
            r_err   <= w_err_next;
        end
    end

    // The read address is the down-counter itself; the shadow's output
    // register provides the one-cycle data lag the datapath expects.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_rd_en        = 1'b0;
        w_coeff_wr     = 1'b0;
        w_coeff_update = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg.commit) begin
                    w_state_next = LOAD;
                    w_cnt_next   = ABITS'(NCOEFF - 1);
                end
            end
            LOAD: begin
                w_coeff_wr = 1'b1;
                w_rd_en    = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = UPDATE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            UPDATE: begin
                w_coeff_update = 1'b1;
                w_state_next   = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign coeff_dat_o    = w_rd_dat;
    assign coeff_wr_o     = w_coeff_wr;
    assign coeff_update_o = w_coeff_update;
    assign cfg.busy       = w_busy;
    assign cfg.done       = r_done;
    assign cfg.err        = r_err;
endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Scoreboard bench for biquad8_coeff_loader: stimulus queues expected stream
// words, update/done/err cycles; a negedge monitor pops and compares them.
module tb_biquad8_coeff_loader;
    localparam int NC = 12;

    typedef struct {
        int          cyc;
        logic [17:0] dat;
    } word_t;

    logic clk;
    logic rst_n;
    logic [17:0] coeff_dat_o;
    logic        coeff_wr_o;
    logic        coeff_update_o;

    biquad8_coeff_loader_if #(.ABITS(4), .CBITS(18)) cfg_bus ();

    biquad8_coeff_loader #(.NSAMP(8), .CBITS(18)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg            (cfg_bus),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o)
    );

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] model [NC];
    word_t       dq[$];
    int          uq[$];
    int          donq[$];
    int          errq[$];
    logic        prev_wr = 1'b0;
    logic        prev_rst = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cfg_write(input int addr, input logic [17:0] d);
        cfg_bus.cfg_addr = 4'(addr);
        cfg_bus.cfg_dat  = d;
        cfg_bus.cfg_wr   = 1'b1;
        if (addr < NC) model[addr] = d;
        else errq.push_back(cyc + 1);
        tick();
        cfg_bus.cfg_wr = 1'b0;
    endtask

    // Commit in the current cycle c; words land in c+2.., update c+NC+1, done c+NC+2.
    task automatic commit_load(input int nwords, input bit full);
        int c;
        c = cyc;
        for (int j = 0; j < nwords; j++) dq.push_back('{c + 2 + j, model[NC - 1 - j]});
        if (full) begin
            uq.push_back(c + NC + 1);
            donq.push_back(c + NC + 2);
        end
        cfg_bus.commit = 1'b1;
        tick();
        cfg_bus.commit = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dat"},    32'(coeff_dat_o),    32'd0);
        chk({tag, "_wr"},     32'(coeff_wr_o),     32'd0);
        chk({tag, "_update"}, 32'(coeff_update_o), 32'd0);
        chk({tag, "_busy"},   32'(cfg_bus.busy),   32'd0);
        chk({tag, "_done"},   32'(cfg_bus.done),   32'd0);
        chk({tag, "_err"},    32'(cfg_bus.err),    32'd0);
    endtask

    // Monitor: a word is presented the cycle after coeff_wr_o, unless reset intervened.
    always @(negedge clk) begin
        word_t w;
        int    e;
        if (prev_wr && prev_rst) begin
            if (dq.size() == 0) begin
                chk("stream_extra", 32'(coeff_dat_o), 32'hFFFF_FFFF);
            end else begin
                w = dq.pop_front();
                $display("cycle %0d word 0x%05h (expect 0x%05h @%0d)", cyc, coeff_dat_o, w.dat, w.cyc);
                chk("stream_dat", 32'(coeff_dat_o), 32'(w.dat));
                chk("stream_cyc", 32'(cyc), 32'(w.cyc));
            end
        end
        if (coeff_update_o) begin
            if (uq.size() == 0) chk("update_extra", 32'(cyc), 32'hFFFF_FFFF);
            else begin
                e = uq.pop_front();
                $display("cycle %0d coeff_update", cyc);
                chk("update_cyc", 32'(cyc), 32'(e));
                chk("update_busy", 32'(cfg_bus.busy), 32'd1);
            end
        end
        if (cfg_bus.done) begin
            if (donq.size() == 0) chk("done_extra", 32'(cyc), 32'hFFFF_FFFF);
            else begin
                e = donq.pop_front();
                $display("cycle %0d done", cyc);
                chk("done_cyc", 32'(cyc), 32'(e));
                chk("done_busy", 32'(cfg_bus.busy), 32'd0);
            end
        end
        if (cfg_bus.err) begin
            if (errq.size() == 0) chk("err_extra", 32'(cyc), 32'hFFFF_FFFF);
            else begin
                e = errq.pop_front();
                $display("cycle %0d err", cyc);
                chk("err_cyc", 32'(cyc), 32'(e));
            end
        end
        prev_wr  <= coeff_wr_o;
        prev_rst <= rst_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst_n            = 1'b0;
        cfg_bus.cfg_addr = '0;
        cfg_bus.cfg_dat  = '0;
        cfg_bus.cfg_wr   = 1'b0;
        cfg_bus.commit   = 1'b0;
        for (int k = 0; k < NC; k++) model[k] = '0;
        run(3);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic load of k+1, then a second commit exactly on the done cycle.
        for (int k = 0; k < NC; k++) cfg_write(k, 18'(k + 1));
        commit_load(NC, 1'b1);
        run(NC + 1);
        commit_load(NC, 1'b1);
        run(NC + 3);

        // Write to the farthest entry in the same cycle as commit.
        cfg_bus.cfg_addr = 4'd11;
        cfg_bus.cfg_dat  = 18'h3FFFF;
        cfg_bus.cfg_wr   = 1'b1;
        model[11]        = 18'h3FFFF;
        commit_load(NC, 1'b1);
        cfg_bus.cfg_wr = 1'b0;
        run(NC + 3);

        // Write and commit during a load are both dropped with one err pulse.
        c = cyc;
        commit_load(NC, 1'b1);
        run(4);
        cfg_bus.cfg_addr = 4'd3;
        cfg_bus.cfg_dat  = 18'h2AAAA;
        cfg_bus.cfg_wr   = 1'b1;
        cfg_bus.commit   = 1'b1;
        errq.push_back(c + 6);
        tick();
        cfg_bus.cfg_wr = 1'b0;
        cfg_bus.commit = 1'b0;
        run(NC + 2);

        // Out-of-range addresses are rejected; the next load is unchanged.
        for (int a = NC; a < 16; a++) cfg_write(a, 18'h15555);
        commit_load(NC, 1'b1);
        run(NC + 3);

        // Reset in LOAD cycle 6: partial stream, no update, then a clean reload.
        commit_load(5, 1'b0);
        run(5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        tick();
        commit_load(NC, 1'b1);
        run(NC + 3);

        run(3);
        chk("stream_left", 32'(dq.size()), 32'd0);
        chk("update_left", 32'(uq.size()), 32'd0);
        chk("done_left",   32'(donq.size()), 32'd0);
        chk("err_left",    32'(errq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
